// File: rtl/core_types_pkg.sv
// Shared core types for the data-memory responder: request/response
// structs, access-length encoding, FSM states and the byte-enable helper.
package core_types_pkg;

    localparam int N_BITS = 32;

    // Access size carried in req_ctrl.len; 2'b11 is reserved.
    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10
    } dmem_len_e;

    typedef struct packed {
        logic       vld;
        logic       mtype;   // 0 = read, 1 = write
        logic [1:0] len;
    } dmem_req_ctrl_t;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic              mtype;
        logic [N_BITS-1:0] rdata;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Byte lanes touched by an access; misaligned low bits are aligned
    // down to the access size and the reserved length acts as a word.
    function automatic logic [3:0] lane_be(input logic [1:0] len, input logic [1:0] lo);
        logic [3:0] be;
        case (len)
            LEN_B:   be = 4'b0001 << lo;
            LEN_H:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Byte-lane storage: four 8-bit lanes per word, synchronous byte-enabled
// write and a registered read. Contents are never reset.
module dmem_sram_bank #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_en,
    input  logic                           i_we,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [3:0][7:0] r_mem [DEPTH_WORDS];
    logic [31:0]     r_rdata;

    // Enabled access: write selected lanes, capture the old word for reads.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) r_mem[i_addr][b] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, IDLE/WAIT/RESP FSM with
// programmable read latency, byte/half/word lane steering.
// Optional macro DMEM_ERR_CHK_EN enables alignment/range error checking;
// without it misaligned accesses are aligned down and addresses wrap.
module dmem_responder
    import core_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  dmem_req_ctrl_t    req_ctrl,
    input  logic [N_BITS-1:0] req_addr,
    input  logic [N_BITS-1:0] req_wdata,
    output logic              req_rdy,
    output dmem_resp_t        resp,
    input  logic              resp_rdy
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  LAT_INIT = 2'(RD_LATENCY - 1);
    localparam dmem_state_e LOAD_ST  = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;

    dmem_state_e r_state, w_state_nxt;
    logic [1:0]  r_cnt;
    logic        r_mtype;
    logic [1:0]  r_len;
    logic [1:0]  r_lo;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_bank_rdata;
    logic [31:0] w_rdata_sel;

    assign w_accept = req_ctrl.vld & req_rdy;

`ifdef DMEM_ERR_CHK_EN
    logic w_hi_err;
    if (IDX_W + 2 < N_BITS) begin : g_hi
        assign w_hi_err = |req_addr[N_BITS-1:IDX_W+2];
    end else begin : g_nohi
        assign w_hi_err = 1'b0;
    end
    assign w_err = w_hi_err
                 | (req_ctrl.len == 2'b11)
                 | ((req_ctrl.len == LEN_H) & req_addr[0])
                 | ((req_ctrl.len == LEN_W) & (|req_addr[1:0]));
`else
    // Upper address bits are intentionally dropped so addresses wrap.
    logic w_unused_addr;
    assign w_unused_addr = ^req_addr[N_BITS-1:IDX_W+2];
    assign w_err = 1'b0;
`endif

    // An erroring write must leave memory untouched.
    assign w_we = w_accept & req_ctrl.mtype & ~w_err;
    assign w_be = lane_be(req_ctrl.len, req_addr[1:0]);

    // Replicate right-justified write data across every candidate lane.
    always_comb begin
        case (req_ctrl.len)
            LEN_B:   w_wdata_rep = {4{req_wdata[7:0]}};
            LEN_H:   w_wdata_rep = {2{req_wdata[15:0]}};
            default: w_wdata_rep = req_wdata;
        endcase
    end

    dmem_sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (req_addr[IDX_W+1:2]),
        .i_wdata (w_wdata_rep),
        .o_rdata (w_bank_rdata)
    );

    // Extract the addressed byte/half, zero-extended; writes and errors give 0.
    always_comb begin
        w_rdata_sel = '0;
        if (!r_mtype && !r_err) begin
            case (r_len)
                LEN_B:   w_rdata_sel = {24'd0, w_bank_rdata[{r_lo, 3'b000} +: 8]};
                LEN_H:   w_rdata_sel = {16'd0, w_bank_rdata[{r_lo[1], 4'b0000} +: 16]};
                default: w_rdata_sel = w_bank_rdata;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Capture request attributes on acceptance; count down the latency in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mtype <= 1'b0;
            r_len   <= '0;
            r_lo    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= LAT_INIT;
            r_mtype <= req_ctrl.mtype;
            r_len   <= req_ctrl.len;
            r_lo    <= req_addr[1:0];
            r_err   <= w_err;
        end else if (r_state == ST_WAIT) begin
            r_cnt   <= r_cnt - 2'd1;
        end
    end

    // Next-state logic; RESP can reload directly on a back-to-back accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = LOAD_ST;
            ST_WAIT: if (r_cnt == 2'd1) w_state_nxt = ST_RESP;
            ST_RESP: if (resp_rdy) w_state_nxt = w_accept ? LOAD_ST : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: response fields are only non-zero while presented in RESP.
    always_comb begin
        req_rdy = (r_state == ST_IDLE) | ((r_state == ST_RESP) & resp_rdy);
        resp    = '0;
        if (r_state == ST_RESP) begin
            resp.vld   = 1'b1;
            resp.err   = r_err;
            resp.mtype = r_mtype;
            resp.rdata = w_rdata_sel;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with read latency
// 1, 3 and 4 sharing clock and reset.
module tb_dmem_responder;
    import core_types_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    dmem_req_ctrl_t ctrl  [3];
    logic [31:0]    addr  [3];
    logic [31:0]    wdata [3];
    logic           rdy   [3];
    logic           rrdy  [3];
    dmem_resp_t     resp  [3];

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_ctrl(ctrl[0]), .req_addr(addr[0]),
        .req_wdata(wdata[0]), .req_rdy(rdy[0]), .resp(resp[0]), .resp_rdy(rrdy[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_ctrl(ctrl[1]), .req_addr(addr[1]),
        .req_wdata(wdata[1]), .req_rdy(rdy[1]), .resp(resp[1]), .resp_rdy(rrdy[1]));
    dmem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_ctrl(ctrl[2]), .req_addr(addr[2]),
        .req_wdata(wdata[2]), .req_rdy(rdy[2]), .resp(resp[2]), .resp_rdy(rrdy[2]));

    // One request from IDLE; returns latency (-1 on timeout) and the response.
    task automatic do_req(input int d, input logic wr, input logic [1:0] ln,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output dmem_resp_t r);
        int n;
        @(negedge clk);
        ctrl[d] = '{vld: 1'b1, mtype: wr, len: ln};
        addr[d] = a; wdata[d] = wd; rrdy[d] = 1'b1;
        @(posedge clk); #1;
        ctrl[d].vld = 1'b0;
        n = 1;
        @(negedge clk);
        while (!resp[d].vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        r   = resp[d];
        lat = resp[d].vld ? n : -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (resp[d] !== '0) begin errs++; $display("FAIL reset_resp[%0d]: got %h want 0", d, resp[d]); end
            checks++; if (rdy[d] !== 1'b1) begin errs++; $display("FAIL reset_rdy[%0d]: got %b want 1", d, rdy[d]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        int lat; dmem_resp_t r;
        do_req(0, 1'b1, LEN_W, 32'h10, 32'hDEADBEEF, lat, r);
        checks++; if (lat !== 1) begin errs++; $display("FAIL word_wr_lat: got %0d want 1", lat); end
        checks++; if (r.err !== 1'b0 || r.mtype !== 1'b1 || r.rdata !== 32'h0) begin errs++; $display("FAIL word_wr_resp: got err=%b mtype=%b rdata=%h want 0/1/0", r.err, r.mtype, r.rdata); end
        do_req(0, 1'b0, LEN_W, 32'h10, 32'h0, lat, r);
        checks++; if (lat !== 1) begin errs++; $display("FAIL word_rd_lat: got %0d want 1", lat); end
        checks++; if (r.err !== 1'b0 || r.mtype !== 1'b0 || r.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL word_rd_resp: got err=%b mtype=%b rdata=%h want 0/0/deadbeef", r.err, r.mtype, r.rdata); end
    endtask

    task automatic test_lanes;
        int lat; dmem_resp_t r;
        do_req(0, 1'b1, LEN_W, 32'h10, 32'h0, lat, r);
        do_req(0, 1'b1, LEN_B, 32'h13, 32'hFFFFFFA5, lat, r);
        do_req(0, 1'b0, LEN_H, 32'h12, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'h0000A500) begin errs++; $display("FAIL half_rd_12: got %h want 0000a500", r.rdata); end
        do_req(0, 1'b0, LEN_B, 32'h13, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'h000000A5) begin errs++; $display("FAIL byte_rd_13: got %h want 000000a5", r.rdata); end
        do_req(0, 1'b0, LEN_W, 32'h10, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'hA5000000) begin errs++; $display("FAIL word_rd_10: got %h want a5000000", r.rdata); end
        do_req(0, 1'b1, LEN_W, 32'h14, 32'h0, lat, r);
        do_req(0, 1'b1, LEN_H, 32'h16, 32'h1234CAFE, lat, r);
        do_req(0, 1'b0, LEN_H, 32'h16, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'h0000CAFE) begin errs++; $display("FAIL half_rd_16: got %h want 0000cafe", r.rdata); end
        do_req(0, 1'b0, LEN_H, 32'h14, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'h0) begin errs++; $display("FAIL half_rd_14: got %h want 0", r.rdata); end
        do_req(0, 1'b0, LEN_B, 32'h16, 32'h0, lat, r);
        checks++; if (r.rdata !== 32'h000000FE) begin errs++; $display("FAIL byte_rd_16: got %h want 000000fe", r.rdata); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ctrl[0] = '{vld: 1'b1, mtype: 1'b1, len: LEN_W};
        addr[0] = 32'h40; wdata[0] = 32'h11223344; rrdy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp[0].vld !== 1'b1 || resp[0].mtype !== 1'b1 || resp[0].rdata !== 32'h0) begin errs++; $display("FAIL b2b_wr_resp: got vld=%b mtype=%b rdata=%h want 1/1/0", resp[0].vld, resp[0].mtype, resp[0].rdata); end
        checks++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL b2b_rdy: got %b want 1", rdy[0]); end
        ctrl[0] = '{vld: 1'b1, mtype: 1'b0, len: LEN_W};
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp[0].vld !== 1'b1 || resp[0].mtype !== 1'b0 || resp[0].rdata !== 32'h11223344) begin errs++; $display("FAIL b2b_raw: got vld=%b mtype=%b rdata=%h want 1/0/11223344", resp[0].vld, resp[0].mtype, resp[0].rdata); end
        ctrl[0].vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp[0].vld !== 1'b0) begin errs++; $display("FAIL b2b_idle: got vld=%b want 0", resp[0].vld); end
    endtask

    task automatic test_latency3;
        int lat; dmem_resp_t r;
        do_req(1, 1'b1, LEN_W, 32'h80, 32'hCAFEF00D, lat, r);
        checks++; if (lat !== 3) begin errs++; $display("FAIL lat3_wr: got %0d want 3", lat); end
        @(negedge clk);
        ctrl[1] = '{vld: 1'b1, mtype: 1'b0, len: LEN_W};
        addr[1] = 32'h80; rrdy[1] = 1'b0;
        @(posedge clk); #1;
        ctrl[1] = '{vld: 1'b1, mtype: 1'b1, len: LEN_W};
        addr[1] = 32'h84; wdata[1] = 32'h0BADF00D;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checks++; if (rdy[1] !== 1'b0) begin errs++; $display("FAIL lat3_rdy n=%0d: got %b want 0", n, rdy[1]); end
            checks++; if (resp[1].vld !== (n >= 3)) begin errs++; $display("FAIL lat3_vld n=%0d: got %b want %b", n, resp[1].vld, (n >= 3)); end
            if (n >= 3) begin
                checks++; if (resp[1].rdata !== 32'hCAFEF00D || resp[1].mtype !== 1'b0) begin errs++; $display("FAIL lat3_hold n=%0d: got mtype=%b rdata=%h want 0/cafef00d", n, resp[1].mtype, resp[1].rdata); end
            end
        end
        rrdy[1] = 1'b1; #1;
        checks++; if (rdy[1] !== 1'b1) begin errs++; $display("FAIL lat3_hs_rdy: got %b want 1", rdy[1]); end
        @(posedge clk); #1;
        ctrl[1].vld = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++; if (resp[1].vld !== (n == 3)) begin errs++; $display("FAIL lat3_b2b_vld n=%0d: got %b want %b", n, resp[1].vld, (n == 3)); end
        end
        checks++; if (resp[1].mtype !== 1'b1 || resp[1].rdata !== 32'h0) begin errs++; $display("FAIL lat3_b2b_resp: got mtype=%b rdata=%h want 1/0", resp[1].mtype, resp[1].rdata); end
        @(posedge clk); #1;
        do_req(1, 1'b0, LEN_W, 32'h84, 32'h0, lat, r);
        checks++; if (lat !== 3 || r.rdata !== 32'h0BADF00D) begin errs++; $display("FAIL lat3_rd84: got lat=%0d rdata=%h want 3/0badf00d", lat, r.rdata); end
    endtask

    task automatic test_misalign;
        int lat; dmem_resp_t r;
        do_req(0, 1'b1, LEN_W, 32'h20, 32'h0, lat, r);
        do_req(0, 1'b1, LEN_W, 32'h21, 32'h12345678, lat, r);
`ifdef DMEM_ERR_CHK_EN
        checks++; if (r.err !== 1'b1 || lat !== 1) begin errs++; $display("FAIL mis_wr: got err=%b lat=%0d want 1/1", r.err, lat); end
        do_req(0, 1'b0, LEN_W, 32'h20, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h0) begin errs++; $display("FAIL mis_rd20: got err=%b rdata=%h want 0/0", r.err, r.rdata); end
        do_req(0, 1'b0, LEN_W, 32'h1020, 32'h0, lat, r);
        checks++; if (r.err !== 1'b1 || r.rdata !== 32'h0) begin errs++; $display("FAIL mis_hi: got err=%b rdata=%h want 1/0", r.err, r.rdata); end
        do_req(0, 1'b0, 2'b11, 32'h20, 32'h0, lat, r);
        checks++; if (r.err !== 1'b1 || r.rdata !== 32'h0) begin errs++; $display("FAIL mis_len3: got err=%b rdata=%h want 1/0", r.err, r.rdata); end
        do_req(0, 1'b0, LEN_B, 32'h21, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h0) begin errs++; $display("FAIL mis_byte21: got err=%b rdata=%h want 0/0", r.err, r.rdata); end
`else
        checks++; if (r.err !== 1'b0 || lat !== 1) begin errs++; $display("FAIL mis_wr: got err=%b lat=%0d want 0/1", r.err, lat); end
        do_req(0, 1'b0, LEN_W, 32'h20, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h12345678) begin errs++; $display("FAIL mis_rd20: got err=%b rdata=%h want 0/12345678", r.err, r.rdata); end
        do_req(0, 1'b0, LEN_W, 32'h1020, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h12345678) begin errs++; $display("FAIL mis_hi: got err=%b rdata=%h want 0/12345678", r.err, r.rdata); end
        do_req(0, 1'b0, 2'b11, 32'h20, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h12345678) begin errs++; $display("FAIL mis_len3: got err=%b rdata=%h want 0/12345678", r.err, r.rdata); end
        do_req(0, 1'b0, LEN_B, 32'h21, 32'h0, lat, r);
        checks++; if (r.err !== 1'b0 || r.rdata !== 32'h00000056) begin errs++; $display("FAIL mis_byte21: got err=%b rdata=%h want 0/56", r.err, r.rdata); end
`endif
    endtask

    task automatic test_reset_wait;
        int lat; dmem_resp_t r;
        do_req(2, 1'b1, LEN_W, 32'h30, 32'h5A5AA5A5, lat, r);
        checks++; if (lat !== 4) begin errs++; $display("FAIL rw_wr_lat: got %0d want 4", lat); end
        @(negedge clk);
        ctrl[2] = '{vld: 1'b1, mtype: 1'b0, len: LEN_W};
        addr[2] = 32'h30;
        @(posedge clk); #1;
        ctrl[2].vld = 1'b0;
        @(negedge clk);
        checks++; if (resp[2].vld !== 1'b0 || rdy[2] !== 1'b0) begin errs++; $display("FAIL rw_wait: got vld=%b rdy=%b want 0/0", resp[2].vld, rdy[2]); end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (resp[2] !== '0) begin errs++; $display("FAIL rw_in_reset: got %h want 0", resp[2]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rdy[2] !== 1'b1) begin errs++; $display("FAIL rw_rdy_release: got %b want 1", rdy[2]); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++; if (resp[2].vld !== 1'b0) begin errs++; $display("FAIL rw_dropped n=%0d: got vld=%b want 0", n, resp[2].vld); end
        end
        do_req(2, 1'b0, LEN_W, 32'h30, 32'h0, lat, r);
        checks++; if (lat !== 4 || r.rdata !== 32'h5A5AA5A5) begin errs++; $display("FAIL rw_readback: got lat=%0d rdata=%h want 4/5a5aa5a5", lat, r.rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            ctrl[d] = '0; addr[d] = '0; wdata[d] = '0; rrdy[d] = 1'b1;
        end
        test_reset;
        test_word;
        test_lanes;
        test_back_to_back;
        test_latency3;
        test_misalign;
        test_reset_wait;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog timeout");
    end

endmodule
